if_id_queue: RTL and testbench

Instruction queue between fetch and decode. Accepts one (PC, instruction) pair per cycle from the fetch stage, fed by the PC register and instruction memory, and buffers it in a small FIFO. Presents entries in order to decode with a valid/ready handshake. A taken jump/branch flushes all buffered entries in the same cycle the PC register loads its new target.

---
 rtl/rv_pkg.sv | 11 +
 rtl/ifq_ram.sv | 25 ++
 rtl/if_id_queue.sv | 106 ++++++++++
 tb/tb_if_id_queue.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared CPU-wide types and constants for the fetch/decode front end.
package rv_pkg;

   typedef logic [31:0] InstAddrBus;
   typedef logic [31:0] InstBus;

   // addi x0, x0, 0 -- what decode sees whenever no real instruction is present
   localparam InstBus     INST_NOP     = 32'h0000_0013;
   localparam InstAddrBus CpuResetAddr = 32'h0000_0000;

endpackage

// File: rtl/ifq_ram.sv
// Storage array for the fetch/decode queue: one synchronous write port,
// one asynchronous read port, no reset (contents are qualified by the queue count).
module ifq_ram #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [63:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [63:0]   rdata
);

   logic [63:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode with a valid/ready output and jump flush.
// Optional zero-latency empty-queue bypass is enabled with `define IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
   import rv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush_i,
   input  InstAddrBus               pc_i,
   input  InstBus                   inst_i,
   input  logic                     inst_valid_i,
   output logic                     inst_ready_o,
   output InstAddrBus               id_pc_o,
   output InstBus                   id_inst_o,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          bypass;
   logic          bypass_take;
   logic [63:0]   head;

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

`ifdef IF_ID_QUEUE_BYPASS_EN
   // An empty queue forwards the fetch beat straight to decode; if decode takes it, it is never stored.
   assign bypass      = empty & inst_valid_i & ~flush_i;
   assign bypass_take = bypass & id_ready_i;
`else
   assign bypass      = 1'b0;
   assign bypass_take = 1'b0;
`endif

   assign push = inst_valid_i & ~full & ~flush_i & ~bypass_take;
   assign pop  = ~empty & id_ready_i & ~flush_i;

   assign inst_ready_o = ~full;
   assign full_o       = full;
   assign count_o      = count;

   ifq_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata ({pc_i, inst_i}),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Stale storage is never shown: without a valid head decode sees a NOP at PC 0.
   always_comb begin
      id_valid_o = 1'b0;
      id_pc_o    = '0;
      id_inst_o  = INST_NOP;
      if (!empty) begin
         id_valid_o = 1'b1;
         id_pc_o    = head[63:32];
         id_inst_o  = head[31:0];
      end else if (bypass) begin
         id_valid_o = 1'b1;
         id_pc_o    = pc_i;
         id_inst_o  = inst_i;
      end
   end

   // Reset and flush both just empty the queue; occupancy has its own counter so full and empty are unambiguous.
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue; follows the DUT build's IF_ID_QUEUE_BYPASS_EN setting.
module tb_if_id_queue;
   import rv_pkg::*;

   localparam int DEPTH = 4;

   logic                     clk;
   logic                     rst_n;
   logic                     flush_i;
   logic [31:0]              pc_i;
   logic [31:0]              inst_i;
   logic                     inst_valid_i;
   logic                     inst_ready_o;
   logic [31:0]              id_pc_o;
   logic [31:0]              id_inst_o;
   logic                     id_valid_o;
   logic                     id_ready_i;
   logic                     full_o;
   logic [$clog2(DEPTH):0]   count_o;

   int compared;
   int mismatched;

   logic [63:0] sb[$];

   if_id_queue #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush_i),
      .pc_i         (pc_i),
      .inst_i       (inst_i),
      .inst_valid_i (inst_valid_i),
      .inst_ready_o (inst_ready_o),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .full_o       (full_o),
      .count_o      (count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Compares outputs against the model mid-cycle, then advances the model and the DUT by one edge.
   task automatic stepCycle();
      logic bypass;
      logic exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_inst;
      int   sz;
      sz = sb.size();
      bypass = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
      bypass = (sz == 0) && inst_valid_i && !flush_i;
`endif
      exp_valid = (sz != 0) || bypass;
      exp_pc    = 32'h0;
      exp_inst  = INST_NOP;
      if (sz != 0) begin
         exp_pc   = sb[0][63:32];
         exp_inst = sb[0][31:0];
      end else if (bypass) begin
         exp_pc   = pc_i;
         exp_inst = inst_i;
      end
      @(negedge clk);
      checkOutput("id_valid", 64'(id_valid_o), 64'(exp_valid));
      checkOutput("id_pc", 64'(id_pc_o), 64'(exp_pc));
      checkOutput("id_inst", 64'(id_inst_o), 64'(exp_inst));
      checkOutput("count", 64'(count_o), 64'(sz));
      checkOutput("full", 64'(full_o), 64'(sz == DEPTH));
      checkOutput("ready", 64'(inst_ready_o), 64'(sz != DEPTH));
      if (!rst_n || flush_i) begin
         sb.delete();
      end else begin
         if (bypass && id_ready_i) begin
            // consumed directly, never stored
         end else begin
            if (sz != 0 && id_ready_i) void'(sb.pop_front());
            if (inst_valid_i && sz < DEPTH) sb.push_back({pc_i, inst_i});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic [31:0] inst,
                                input logic ready, input logic flush);
      inst_valid_i = valid;
      pc_i         = pc;
      inst_i       = inst;
      id_ready_i   = ready;
      flush_i      = flush;
      stepCycle();
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      rst_n        = 1'b0;
      flush_i      = 1'b0;
      pc_i         = '0;
      inst_i       = '0;
      inst_valid_i = 1'b0;
      id_ready_i   = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] reset and idle");
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] fill to full, then drain");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h99, 32'hFF, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h98, 32'hFE, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] streaming push and pop");
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'h10 + 32'(i), 32'hB0 + 32'(i), 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] flush drops same-cycle push");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h30 + 32'(i), 32'hC0 + 32'(i), 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h40, 32'hD0, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h40, 32'hD0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h50 + 32'(i), 32'hE0 + 32'(i), 1'b0, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b1, 32'h60, 32'hE9, 1'b1, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      $display("[TB] empty queue push with decode ready");
      applyStimulus(1'b1, 32'h8, 32'h00500093, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
